// File: rtl/moore_1011_gen.sv
// Moore-style serial pattern generator: shifts a WIDTH-bit pattern out MSB-first,
// repeating it repeat_cnt+1 times with gap_len idle cycles between frames.
module moore_1011_gen #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
   parameter int               REP_W   = 4,
   parameter int               GAP_W   = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             load_pattern,
   input  logic [WIDTH-1:0] pattern_in,
   input  logic [REP_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap_len,
   output logic             sequence_out,
   output logic             frame_start,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
   localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
   localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

   logic [1:0]       state_r,    state_s;
   logic [WIDTH-1:0] shift_r,    shift_s;
   logic [WIDTH-1:0] pattern_r,  pattern_s;
   logic [CNT_W-1:0] bit_cnt_r,  bit_cnt_s;
   logic [REP_W-1:0] rep_r,      rep_s;
   logic [GAP_W-1:0] gap_len_r,  gap_len_s;
   logic [GAP_W-1:0] gap_cnt_r,  gap_cnt_s;
   logic             seq_s;
   logic             frame_start_s;
   logic             busy_s;
   logic             done_s;

   // Next-state and next-output logic; outputs describe the cycle after the edge.
   always_comb begin
      state_s       = state_r;
      shift_s       = shift_r;
      pattern_s     = pattern_r;
      bit_cnt_s     = bit_cnt_r;
      rep_s         = rep_r;
      gap_len_s     = gap_len_r;
      gap_cnt_s     = gap_cnt_r;
      seq_s         = 1'b0;
      frame_start_s = 1'b0;
      busy_s        = 1'b0;
      done_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (load_pattern) begin
               pattern_s = pattern_in;
            end else begin
               pattern_s = pattern_r;
            end
            // pattern_s already reflects a simultaneous load, so that pattern goes out.
            if (start) begin
               state_s       = ST_SHIFT;
               shift_s       = pattern_s;
               bit_cnt_s     = CNT_LAST;
               rep_s         = repeat_cnt;
               gap_len_s     = gap_len;
               seq_s         = pattern_s[WIDTH-1];
               frame_start_s = 1'b1;
               busy_s        = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            busy_s = 1'b1;
            if (bit_cnt_r != CNT_ZERO) begin
               shift_s   = {shift_r[WIDTH-2:0], 1'b0};
               bit_cnt_s = bit_cnt_r - CNT_ONE;
               seq_s     = shift_r[WIDTH-2];
            end else if (rep_r != REP_ZERO) begin
               rep_s = rep_r - REP_ONE;
               if (gap_len_r != GAP_ZERO) begin
                  state_s   = ST_GAP;
                  gap_cnt_s = gap_len_r - GAP_ONE;
               end else begin
                  shift_s       = pattern_r;
                  bit_cnt_s     = CNT_LAST;
                  seq_s         = pattern_r[WIDTH-1];
                  frame_start_s = 1'b1;
               end
            end else begin
               state_s = ST_DONE;
               busy_s  = 1'b0;
               done_s  = 1'b1;
            end
         end
         ST_GAP: begin
            busy_s = 1'b1;
            if (gap_cnt_r != GAP_ZERO) begin
               gap_cnt_s = gap_cnt_r - GAP_ONE;
            end else begin
               state_s       = ST_SHIFT;
               shift_s       = pattern_r;
               bit_cnt_s     = CNT_LAST;
               seq_s         = pattern_r[WIDTH-1];
               frame_start_s = 1'b1;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         shift_r      <= {WIDTH{1'b0}};
         pattern_r    <= PATTERN;
         bit_cnt_r    <= CNT_ZERO;
         rep_r        <= REP_ZERO;
         gap_len_r    <= GAP_ZERO;
         gap_cnt_r    <= GAP_ZERO;
         sequence_out <= 1'b0;
         frame_start  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_r      <= state_s;
         shift_r      <= shift_s;
         pattern_r    <= pattern_s;
         bit_cnt_r    <= bit_cnt_s;
         rep_r        <= rep_s;
         gap_len_r    <= gap_len_s;
         gap_cnt_r    <= gap_cnt_s;
         sequence_out <= seq_s;
         frame_start  <= frame_start_s;
         busy         <= busy_s;
         done         <= done_s;
      end
   end

endmodule
